// File: rtl/ovl_combo_param.sv
// ovl_combo_param: edge/next/always/never/frame checker cell with chained config check; out is combinational, out_delayed one enabled cycle later.
// No backpressure: enable=0 stutters and freezes all state. Define OVL_COMBO_COUNT_EN to build the fire_count/fire_sticky counters.
module ovl_combo_param #(
   parameter int CKS_W = 3,
   parameter int CNT_W = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             enable,
   input  logic [CKS_W-1:0] num_cks,
   input  logic             start_event,
   input  logic             test_expr,
   input  logic [2:0]       select,
   input  logic             prevConfigInvalid,
   output logic             out,
   output logic             out_delayed,
   output logic             configInvalid,
   output logic [CNT_W-1:0] fire_count,
   output logic             fire_sticky
);
   localparam int DEPTH = (1 << CKS_W) - 1;

   typedef enum logic {IDLE, ARMED} frame_state_t;

   logic [DEPTH-1:0] hist;
   logic [DEPTH:0]   hist_ext;
   logic [CKS_W-1:0] hist_idx;
   frame_state_t     state;
   logic [CKS_W-1:0] counter;
   logic             mode_uses_cks;
   logic             raw_fire;

   assign mode_uses_cks = (select == 3'd0) || (select == 3'd1) || (select == 3'd4);
   assign configInvalid = prevConfigInvalid || (select >= 3'd5) ||
                          (mode_uses_cks && (num_cks == '0));

   // hist[k-1] holds start_event from k enabled cycles ago; the padded top bit
   // keeps the num_cks==0 lookup in range (that case is a config error anyway).
   assign hist_ext = {1'b0, hist};
   assign hist_idx = num_cks - CKS_W'(1);

   always_comb begin
      raw_fire = 1'b0;
      case (select)
         3'd0:    raw_fire = start_event && !hist[0] && !test_expr;
         3'd1:    raw_fire = hist_ext[hist_idx] && !test_expr;
         3'd2:    raw_fire = !test_expr;
         3'd3:    raw_fire = test_expr;
         3'd4:    raw_fire = (state == ARMED) && (counter == CKS_W'(1)) && !test_expr;
         default: raw_fire = 1'b0;
      endcase
   end

   assign out = !rst && enable && !configInvalid && raw_fire;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         hist        <= '0;
         out_delayed <= 1'b0;
      end else if (enable) begin
         hist        <= (hist << 1) | DEPTH'(start_event);
         out_delayed <= out;
      end
   end

   // Frame window: leaving mode 4 drops any open window, even on a stutter cycle.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state   <= IDLE;
         counter <= '0;
      end else if (select != 3'd4) begin
         state <= IDLE;
      end else if (enable) begin
         case (state)
            IDLE: begin
               if (start_event && !configInvalid) begin
                  counter <= num_cks;
                  state   <= ARMED;
               end
            end
            ARMED: begin
               if (test_expr || (counter == CKS_W'(1))) begin
                  state <= IDLE;
               end else begin
                  counter <= counter - CKS_W'(1);
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

`ifdef OVL_COMBO_COUNT_EN
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         fire_count  <= '0;
         fire_sticky <= 1'b0;
      end else if (out) begin
         if (fire_count != '1) begin
            fire_count <= fire_count + CNT_W'(1);
         end
         fire_sticky <= 1'b1;
      end
   end
`else
   assign fire_count  = '0;
   assign fire_sticky = 1'b0;
`endif

endmodule

// File: tb/tb_ovl_combo_param.sv
// Bench for ovl_combo_param: directed scenarios with fixed expectations plus a randomized run against a queue-based model.
module tb_ovl_combo_param;
   localparam int CKS_W = 3;
   localparam int CNT_W = 2;
`ifdef OVL_COMBO_COUNT_EN
   localparam bit COUNT_EN = 1'b1;
`else
   localparam bit COUNT_EN = 1'b0;
`endif

   logic             clk = 1'b0;
   logic             rst = 1'b0;
   logic             enable = 1'b0;
   logic [CKS_W-1:0] num_cks = '0;
   logic             start_event = 1'b0;
   logic             test_expr = 1'b0;
   logic [2:0]       select = '0;
   logic             prevConfigInvalid = 1'b0;
   logic             out;
   logic             out_delayed;
   logic             configInvalid;
   logic [CNT_W-1:0] fire_count;
   logic             fire_sticky;

   int total = 0;
   int bad = 0;

   ovl_combo_param #(.CKS_W(CKS_W), .CNT_W(CNT_W)) dut (
      .clk(clk), .rst(rst), .enable(enable), .num_cks(num_cks),
      .start_event(start_event), .test_expr(test_expr), .select(select),
      .prevConfigInvalid(prevConfigInvalid), .out(out), .out_delayed(out_delayed),
      .configInvalid(configInvalid), .fire_count(fire_count), .fire_sticky(fire_sticky)
   );

   always #5 clk = ~clk;

   // Reference model: start_event history per enabled cycle (newest first),
   // frame window as "armed at enabled-cycle index N for L cycles".
   bit m_hist[$];
   int m_nen;
   bit m_armed;
   int m_arm_at;
   int m_len;
   bit m_od;
   int m_cnt;
   bit m_sticky;

   task automatic m_reset();
      m_hist.delete();
      m_nen = 0; m_armed = 0; m_arm_at = 0; m_len = 0;
      m_od = 0; m_cnt = 0; m_sticky = 0;
   endtask

   function automatic bit m_cfg();
      int s = int'(select);
      return prevConfigInvalid || (s >= 5) || ((int'(num_cks) == 0) && (s == 0 || s == 1 || s == 4));
   endfunction

   function automatic bit m_out();
      bit raw = 0;
      int k = int'(num_cks);
      case (int'(select))
         0: raw = start_event && !(m_hist.size() > 0 && m_hist[0]) && !test_expr;
         1: raw = (k > 0) && (m_hist.size() >= k) && m_hist[k-1] && !test_expr;
         2: raw = !test_expr;
         3: raw = test_expr;
         4: raw = m_armed && ((m_nen - m_arm_at) == m_len) && !test_expr;
         default: raw = 0;
      endcase
      return !rst && enable && !m_cfg() && raw;
   endfunction

   task automatic m_clock();
      bit o;
      bit c;
      o = m_out();
      c = m_cfg();
      if (rst) begin
         m_reset();
         return;
      end
      if (int'(select) != 4) begin
         m_armed = 0;
      end else if (enable) begin
         if (m_armed) begin
            if (test_expr || ((m_nen - m_arm_at) == m_len)) m_armed = 0;
         end else if (start_event && !c) begin
            m_armed = 1; m_arm_at = m_nen; m_len = int'(num_cks);
         end
      end
      if (enable) begin
         m_od = o;
         if (o) begin
            m_sticky = 1;
            if (m_cnt < (1 << CNT_W) - 1) m_cnt++;
         end
         m_hist.push_front(start_event);
         if (m_hist.size() > 8) void'(m_hist.pop_back());
         m_nen++;
      end
   endtask

   task automatic set_in(input bit r, input bit en, input int nck, input bit se,
                         input bit te, input int sel, input bit pci);
      @(negedge clk);
      rst = r; enable = en; num_cks = CKS_W'(nck); start_event = se;
      test_expr = te; select = 3'(sel); prevConfigInvalid = pci;
      if (r) m_reset();
      #2;
   endtask

   task automatic do_reset();
      @(negedge clk);
      rst = 1'b1; enable = 1'b0; start_event = 1'b0; test_expr = 1'b0;
      select = 3'd0; num_cks = CKS_W'(1); prevConfigInvalid = 1'b0;
      m_reset();
      @(posedge clk);
      #1 rst = 1'b0;
   endtask

   task automatic test_reset();
      @(negedge clk);
      rst = 1'b1; enable = 1'b1; select = 3'd2; test_expr = 1'b0;
      start_event = 1'b0; num_cks = CKS_W'(3); prevConfigInvalid = 1'b0;
      #2;
      total++; if (out !== 1'b0) begin bad++; $display("FAIL rst_out got=%b want=0", out); end
      total++; if (out_delayed !== 1'b0) begin bad++; $display("FAIL rst_od got=%b want=0", out_delayed); end
      total++; if (fire_count !== '0) begin bad++; $display("FAIL rst_cnt got=%0d want=0", fire_count); end
      total++; if (fire_sticky !== 1'b0) begin bad++; $display("FAIL rst_sticky got=%b want=0", fire_sticky); end
      @(posedge clk);
      #1 rst = 1'b0;
      set_in(0, 1, 3, 0, 0, 2, 0);
      total++; if (out !== 1'b1) begin bad++; $display("FAIL rst_first_fire got=%b want=1", out); end
      total++; if (out_delayed !== 1'b0) begin bad++; $display("FAIL rst_first_od got=%b want=0", out_delayed); end
      set_in(0, 1, 3, 0, 1, 2, 0);
      total++; if (out !== 1'b0) begin bad++; $display("FAIL rst_second_out got=%b want=0", out); end
      total++; if (out_delayed !== 1'b1) begin bad++; $display("FAIL rst_second_od got=%b want=1", out_delayed); end
   endtask

   task automatic test_next();
      do_reset();
      for (int c = 0; c <= 17; c++) begin
         set_in(0, 1, 3, c == 10, 0, 1, 0);
         total++; if (out !== (c == 13)) begin bad++; $display("FAIL next_out c=%0d got=%b want=%b", c, out, c == 13); end
         total++; if (out_delayed !== (c == 14)) begin bad++; $display("FAIL next_od c=%0d got=%b want=%b", c, out_delayed, c == 14); end
      end
   endtask

   task automatic test_stutter();
      do_reset();
      for (int c = 0; c <= 18; c++) begin
         set_in(0, !(c == 11 || c == 12), 3, c == 10, 0, 1, 0);
         total++; if (out !== (c == 15)) begin bad++; $display("FAIL stut_out c=%0d got=%b want=%b", c, out, c == 15); end
         total++; if (out_delayed !== (c == 16)) begin bad++; $display("FAIL stut_od c=%0d got=%b want=%b", c, out_delayed, c == 16); end
      end
      // out_delayed must hold its 1 across disabled cycles
      set_in(0, 1, 3, 0, 0, 2, 0);
      for (int c = 0; c < 3; c++) begin
         set_in(0, c == 2, 3, 0, 1, 2, 0);
         total++; if (out_delayed !== 1'b1) begin bad++; $display("FAIL stut_hold c=%0d got=%b want=1", c, out_delayed); end
      end
      set_in(0, 1, 3, 0, 1, 2, 0);
      total++; if (out_delayed !== 1'b0) begin bad++; $display("FAIL stut_release got=%b want=0", out_delayed); end
   endtask

   task automatic test_frame();
      bit eo;
      for (int run = 0; run < 4; run++) begin
         do_reset();
         for (int c = 0; c <= 12; c++) begin
            case (run)
               0: begin set_in(0, 1, 2, c == 5, 0, 4, 0); eo = (c == 7); end
               1: begin set_in(0, 1, 2, c == 5 || c == 9, c == 6, 4, 0); eo = (c == 11); end
               2: begin set_in(0, 1, 2, c == 5 || c == 6, c == 5, 4, 0); eo = (c == 7); end
               default: begin set_in(c == 6, 1, 3, c == 5, 0, 4, 0); eo = 1'b0; end
            endcase
            total++; if (out !== eo) begin bad++; $display("FAIL frame%0d_out c=%0d got=%b want=%b", run, c, out, eo); end
         end
      end
   endtask

   task automatic test_edge();
      do_reset();
      for (int c = 0; c <= 11; c++) begin
         set_in(c == 6, 1, 3, c >= 3 && c <= 8, 0, 0, 0);
         total++; if (out !== (c == 3 || c == 7)) begin bad++; $display("FAIL edge_out c=%0d got=%b want=%b", c, out, c == 3 || c == 7); end
         total++; if (out_delayed !== (c == 4 || c == 8)) begin bad++; $display("FAIL edge_od c=%0d got=%b want=%b", c, out_delayed, c == 4 || c == 8); end
      end
   endtask

   task automatic test_config();
      int  t_nck[6] = '{0, 3, 3, 0, 0, 7};
      int  t_sel[6] = '{1, 6, 2, 2, 3, 4};
      bit  t_pci[6] = '{0, 0, 1, 0, 0, 0};
      bit  t_cfg[6] = '{1, 1, 1, 0, 0, 0};
      bit  t_out[6] = '{0, 0, 0, 1, 1, 0};
      do_reset();
      for (int i = 0; i < 6; i++) begin
         set_in(0, 1, t_nck[i], 0, t_sel[i] == 3, t_sel[i], t_pci[i]);
         total++; if (configInvalid !== t_cfg[i]) begin bad++; $display("FAIL cfg_inv i=%0d got=%b want=%b", i, configInvalid, t_cfg[i]); end
         total++; if (out !== t_out[i]) begin bad++; $display("FAIL cfg_out i=%0d got=%b want=%b", i, out, t_out[i]); end
      end
   endtask

   task automatic test_count();
      int ec;
      do_reset();
      for (int c = 0; c <= 8; c++) begin
         set_in(0, 1, 3, 0, c >= 6, 2, 0);
         ec = COUNT_EN ? ((c < 3) ? c : 3) : 0;
         total++; if (fire_count !== CNT_W'(ec)) begin bad++; $display("FAIL cnt c=%0d got=%0d want=%0d", c, fire_count, ec); end
         total++; if (fire_sticky !== (COUNT_EN && c > 0)) begin bad++; $display("FAIL sticky c=%0d got=%b want=%b", c, fire_sticky, COUNT_EN && c > 0); end
      end
   endtask

   task automatic test_random();
      int sel = 1;
      int nck = 3;
      int ec;
      do_reset();
      for (int c = 0; c < 1500; c++) begin
         if ($urandom_range(0, 24) == 0)
            sel = ($urandom_range(0, 7) < 7) ? $urandom_range(0, 4) : $urandom_range(5, 7);
         if ($urandom_range(0, 24) == 0) nck = $urandom_range(0, 7);
         set_in($urandom_range(0, 99) == 0, $urandom_range(0, 9) < 8, nck,
                $urandom_range(0, 3) == 0, $urandom_range(0, 4) == 0, sel,
                $urandom_range(0, 39) == 0);
         ec = COUNT_EN ? m_cnt : 0;
         total++; if (out !== m_out()) begin bad++; $display("FAIL rnd_out c=%0d got=%b want=%b", c, out, m_out()); end
         total++; if (out_delayed !== m_od) begin bad++; $display("FAIL rnd_od c=%0d got=%b want=%b", c, out_delayed, m_od); end
         total++; if (configInvalid !== m_cfg()) begin bad++; $display("FAIL rnd_cfg c=%0d got=%b want=%b", c, configInvalid, m_cfg()); end
         total++; if (fire_count !== CNT_W'(ec)) begin bad++; $display("FAIL rnd_cnt c=%0d got=%0d want=%0d", c, fire_count, ec); end
         total++; if (fire_sticky !== (COUNT_EN && m_sticky)) begin bad++; $display("FAIL rnd_sticky c=%0d got=%b want=%b", c, fire_sticky, COUNT_EN && m_sticky); end
         m_clock();
      end
   endtask

   initial begin
      test_reset();
      test_next();
      test_stutter();
      test_frame();
      test_edge();
      test_config();
      test_count();
      test_random();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule

// File: doc/ovl_combo_param.md
OVL_COMBO_PARAM -- requirements
Module: ovl_combo_param

Interface
- REQ-001 SHALL have parameter CKS_W, default 3: width of num_cks; maximum delay is 2^CKS_W-1 enabled cycles.
- REQ-002 SHALL have parameter CNT_W, default 8: width of fire_count.
- REQ-003 SHALL have port clk, input, 1: single clock; all state on its rising edge.
- REQ-004 SHALL have port rst, input, 1: reset, asynchronous and active-high.
- REQ-005 SHALL have port enable, input, 1: qualifies the cycle; 0 = stutter.
- REQ-006 SHALL have port num_cks, input, CKS_W: delay or window length in enabled cycles.
- REQ-007 SHALL have port start_event, input, 1: trigger.
- REQ-008 SHALL have port test_expr, input, 1: checked expression.
- REQ-009 SHALL have port select, input, 3: mode (0 edge, 1 next, 2 always, 3 never, 4 frame, 5-7 reserved).
- REQ-010 SHALL have port prevConfigInvalid, input, 1: chained invalid from the upstream cell.
- REQ-011 SHALL have port out, output, 1: combinational fire.
- REQ-012 SHALL have port out_delayed, output, 1: registered out.
- REQ-013 SHALL have port configInvalid, output, 1: combinational configuration error.
- REQ-014 SHALL have port fire_count, output, CNT_W: saturating count of fires.
- REQ-015 SHALL have port fire_sticky, output, 1: set at first fire.

Function
- REQ-016 SHALL drive configInvalid = prevConfigInvalid | select>=5 | (num_cks==0 & select in {0,1,4}).
- REQ-017 SHALL force out=0 when rst, ~enable or configInvalid.
- REQ-018 SHALL, in mode 0, fire when start_event=1, the start_event registered on the previous enabled cycle is 0, and test_expr=0.
- REQ-019 SHALL, in mode 1, fire when start_event was 1 exactly num_cks enabled cycles earlier and test_expr=0 now.
- REQ-019a SHALL store the mode-1 history in a (2^CKS_W-1)-deep shift register that shifts only on enabled cycles, in every mode.
- REQ-020 SHALL, in mode 2, fire when test_expr=0.
- REQ-021 SHALL, in mode 3, fire when test_expr=1.
- REQ-022 SHALL, in mode 4, implement an FSM with states IDLE and ARMED.
- REQ-022a SHALL, in mode 4 IDLE, load counter=num_cks and go to ARMED on an enabled start_event.
- REQ-023 SHALL, in mode 4 ARMED on each enabled cycle: go to IDLE with no fire if test_expr=1; else fire and go to IDLE if counter==1; else decrement the counter.
- REQ-024 SHALL ignore, in mode 4, start_event while ARMED and test_expr on the arming cycle.
- REQ-024a SHALL hold the frame FSM in IDLE whenever select!=4, including on a mid-window select change.
- REQ-025 SHALL hold all state (history, previous start, FSM, counter, out_delayed, fire_count, fire_sticky) unchanged on ~enable & ~rst cycles.
- REQ-026 SHALL load out_delayed <= out on every enabled cycle, giving 1-cycle latency.
- REQ-027 SHALL increment fire_count when out=1, saturating at 2^CNT_W-1, with no wrap.

Reset
- REQ-028 SHALL, on rst=1, clear asynchronously: history, previous start, FSM=IDLE, counter=0, out_delayed=0, fire_count=0, fire_sticky=0.
- REQ-029 SHALL abort an ARMED window on reset mid-operation with no fire.
- REQ-029a SHALL allow the first fire no earlier than the first enabled cycle after rst deasserts.

Configuration
- REQ-030 SHALL, with macro OVL_COMBO_COUNT_EN defined, implement fire_count and fire_sticky per REQ-027/REQ-028.
- REQ-031 SHALL, without OVL_COMBO_COUNT_EN, keep fire_count and fire_sticky as ports tied to 0 with no counter logic synthesized.
- REQ-031a SHALL keep all other behaviour identical in both configurations.

Verification
- REQ-032 SHALL cover: select=1, num_cks=3, enable=1, start_event pulse at cycle 10, test_expr=0 -> out=1 at cycle 13 only, out_delayed=1 at cycle 14.
- REQ-033 SHALL cover: the REQ-032 case with enable=0 at cycles 11-12 -> out=1 at cycle 15, and state held during the stutter.
- REQ-034 SHALL cover: select=4, num_cks=2, start at cycle 5, test_expr=0 -> out=1 at cycle 7; repeated with test_expr=1 at cycle 6 -> no fire, FSM IDLE at cycle 7.
- REQ-035 SHALL cover: select=0, start_event held 1 for cycles 3-8 -> single fire at cycle 3; rst pulse at cycle 6 -> fire again at the first enabled cycle after release.
- REQ-036 SHALL cover: num_cks=0 with select=1, or select=6, or prevConfigInvalid=1 -> configInvalid=1 and out=0.
- REQ-037 SHALL cover: with OVL_COMBO_COUNT_EN and CNT_W=2, select=2, test_expr=0 for 6 cycles -> fire_count=3 and fire_sticky=1; without the macro -> both outputs 0.
